// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: op encodings, FSM states
// and default datapath sizes.
package shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef logic [1:0] shift_op_t;
  typedef logic [1:0] state_t;

  localparam shift_op_t SH_SLL = 2'b00;
  localparam shift_op_t SH_SRL = 2'b01;
  localparam shift_op_t SH_SRA = 2'b10;
  localparam shift_op_t SH_SLA = 2'b11;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/iter_shift_unit_if.sv
// Issue/writeback bundle between decode and the iterative shift unit.
// The ovf signal exists only when SHIFT_OVF_EN is defined.
interface iter_shift_unit_if import shift_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
);

  logic               start;
  shift_op_t          op;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
`ifdef SHIFT_OVF_EN
  logic               ovf;
`endif

  modport master (
    output start, op, operand, shamt,
`ifdef SHIFT_OVF_EN
    input  ovf,
`endif
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand, shamt,
`ifdef SHIFT_OVF_EN
    output ovf,
`endif
    output busy, done, result
  );

endinterface

// File: rtl/shift_step.sv
// Single-bit shift step for one op; purely combinational.
module shift_step import shift_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_op_t        op_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      SH_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      SH_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
      SH_SRA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      // sign kept, bit W-2 falls out
      SH_SLA:  data_o = {data_i[WIDTH-1], data_i[WIDTH-3:0], 1'b0};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: one shift step per clock until shamt is used up.
// Define SHIFT_OVF_EN to add the sticky SLA overflow flag (ovf).
module iter_shift_unit import shift_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  iter_shift_unit_if.slave bus
);

  state_t             state_q, state_d;
  shift_op_t          op_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] count_q;
  logic [WIDTH-1:0]   step_out;
  logic               accept;
  logic               last_step;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_step = (state_q == SHIFT) && (count_q == SHAMT_W'(1));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (work_q),
    .op_i   (op_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // result only moves on the edge that enters DONE, so it is stable otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= SH_SLL;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.op;
        work_q  <= bus.operand;
        count_q <= bus.shamt;
        if (bus.shamt == '0) result_q <= bus.operand;
      end else if (state_q == SHIFT) begin
        work_q  <= step_out;
        count_q <= count_q - SHAMT_W'(1);
        if (last_step) result_q <= step_out;
      end
    end
  end

`ifdef SHIFT_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if ((state_q == SHIFT) && (op_q == SH_SLA) &&
                 (work_q[WIDTH-1] != work_q[WIDTH-2])) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit; ovf checks are active when
// SHIFT_OVF_EN is defined.
module tb_iter_shift_unit;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  iter_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: whole shift computed in one go from the op definitions
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x, input int n);
    case (op)
      SH_SLL:  return x << n;
      SH_SRL:  return x >> n;
      SH_SRA:  return 32'($signed(x) >>> n);
      default: return {x[31], 31'(x[30:0] << n)};
    endcase
  endfunction

  // SLA overflows if any bit that passes through position 30 differs from the sign
  function automatic logic ref_ovf(input logic [1:0] op, input logic [31:0] x, input int n);
    logic [30:0] diff;
    diff = x[30:0] ^ {31{x[31]}};
    return (op == SH_SLA) && (n > 0) && ((diff >> (31 - n)) != 31'd0);
  endfunction

  // start is sampled at the next edge (t); returns at the negedge of cycle t+1
  task automatic launch(input logic [1:0] op, input logic [31:0] x, input logic [4:0] n);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand = x; bus.shamt = n;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'($urandom); bus.operand = $urandom; bus.shamt = 5'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = SH_SLL; bus.operand = '0; bus.shamt = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else passed++;
    checks++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h expected 0", bus.result); else passed++;
`ifdef SHIFT_OVF_EN
    checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus.ovf); else passed++;
`endif
    rst_n = 1'b1;
    $display("reset: busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
  endtask

  task automatic test_sra_timing;
    launch(SH_SRA, 32'h8000_0000, 5'd4);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (bus.busy !== (k <= 5) || bus.done !== (k == 5))
        $display("FAIL sra_timing: cycle t+%0d busy=%b done=%b expected busy=%b done=%b",
                 k, bus.busy, bus.done, (k <= 5), (k == 5));
      else passed++;
      if (k >= 5) begin
        checks++;
        if (bus.result !== 32'hF800_0000)
          $display("FAIL sra_result: cycle t+%0d got %h expected f8000000", k, bus.result);
        else passed++;
      end
    end
    $display("sra 80000000>>>4: result=%h", bus.result);
  endtask

  task automatic test_sll_max;
    int lat;
    launch(SH_SLL, 32'hFFFF_FFFF, 5'd31);
    wait_done(lat);
    checks++; if (lat != 32) $display("FAIL sll31_latency: got %0d expected 32", lat); else passed++;
    checks++; if (bus.result !== 32'h8000_0000) $display("FAIL sll31_result: got %h expected 80000000", bus.result); else passed++;
    $display("sll ffffffff<<31: lat=%0d result=%h", lat, bus.result);
  endtask

  task automatic test_sla;
    int lat;
    launch(SH_SLA, 32'h4000_0001, 5'd1);
    wait_done(lat);
    checks++; if (lat != 2 || bus.result !== 32'h2) $display("FAIL sla1: got lat=%0d result=%h expected lat=2 result=00000002", lat, bus.result); else passed++;
`ifdef SHIFT_OVF_EN
    checks++; if (bus.ovf !== 1'b1) $display("FAIL sla1_ovf: got %b expected 1", bus.ovf); else passed++;
`endif
    $display("sla 40000001 by 1: result=%h", bus.result);
    launch(SH_SLA, 32'h3, 5'd2);
    wait_done(lat);
    checks++; if (lat != 3 || bus.result !== 32'hC) $display("FAIL sla2: got lat=%0d result=%h expected lat=3 result=0000000c", lat, bus.result); else passed++;
`ifdef SHIFT_OVF_EN
    checks++; if (bus.ovf !== 1'b0) $display("FAIL sla2_ovf: got %b expected 0", bus.ovf); else passed++;
`endif
    $display("sla 00000003 by 2: result=%h", bus.result);
  endtask

  task automatic test_zero_shift;
    int lat;
    launch(SH_SRL, 32'h1234_5678, 5'd0);
    wait_done(lat);
    checks++; if (lat != 1) $display("FAIL zero_latency: got %0d expected 1", lat); else passed++;
    checks++; if (bus.result !== 32'h1234_5678) $display("FAIL zero_result: got %h expected 12345678", bus.result); else passed++;
    $display("srl by 0: lat=%0d result=%h", lat, bus.result);
  endtask

  task automatic test_back_to_back;
    int stray;
    stray = 0;
    launch(SH_SLL, 32'h1, 5'd8);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.done === 1'b1 && k != 9 && k != 15) stray++;
      if (k == 9) begin
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 32'h100)
          $display("FAIL b2b_first: done=%b result=%h expected done=1 result=00000100", bus.done, bus.result);
        else passed++;
      end
      if (k == 10) begin
        checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle: busy=%b expected 0", bus.busy); else passed++;
      end
      if (k == 15) begin
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 32'hF)
          $display("FAIL b2b_second: done=%b result=%h expected done=1 result=0000000f", bus.done, bus.result);
        else passed++;
      end
      bus.start = (k == 3 || k == 10);
      bus.op = SH_SRL; bus.operand = 32'hF0; bus.shamt = 5'd4;
    end
    checks++; if (stray != 0) $display("FAIL b2b_stray_done: got %0d extra pulses expected 0", stray); else passed++;
    $display("back_to_back: result=%h", bus.result);
  endtask

  task automatic test_abort;
    int lat;
    int stray;
    stray = 0;
    launch(SH_SRA, 32'h8000_1234, 5'd10);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.done === 1'b1) stray++;
      if (k == 5) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.result !== 32'h0)
          $display("FAIL abort_state: busy=%b result=%h expected busy=0 result=00000000", bus.busy, bus.result);
        else passed++;
      end
      rst_n = (k != 4);
    end
    checks++; if (stray != 0) $display("FAIL abort_done: got %0d pulses expected 0", stray); else passed++;
    launch(SH_SLL, 32'h3, 5'd2);
    wait_done(lat);
    checks++; if (lat != 3 || bus.result !== 32'hC) $display("FAIL abort_recover: got lat=%0d result=%h expected lat=3 result=0000000c", lat, bus.result); else passed++;
    $display("abort then sll 3<<2: result=%h", bus.result);
  endtask

  task automatic test_random;
    int lat;
    logic [1:0]  op;
    logic [31:0] x;
    logic [4:0]  n;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom);
      x  = $urandom;
      n  = 5'($urandom_range(0, 31));
      launch(op, x, n);
      wait_done(lat);
      checks++; if (lat != int'(n) + 1) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, int'(n) + 1); else passed++;
      checks++; if (bus.result !== ref_result(op, x, int'(n))) $display("FAIL rand_result[%0d]: op=%0d x=%h n=%0d got %h expected %h", i, op, x, n, bus.result, ref_result(op, x, int'(n))); else passed++;
`ifdef SHIFT_OVF_EN
      checks++; if (bus.ovf !== ref_ovf(op, x, int'(n))) $display("FAIL rand_ovf[%0d]: got %b expected %b", i, bus.ovf, ref_ovf(op, x, int'(n))); else passed++;
`endif
      $display("rand[%0d] op=%0d x=%h n=%0d -> %h", i, op, x, n, bus.result);
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_sra_timing();
    test_sll_max();
    test_sla();
    test_zero_shift();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
